car_waypoint_nav: RTL and testbench
===================================

Name: car_waypoint_nav

Overview:
- Parametrised successor to the single-target car controller.
- Accepts a queue of (X,Y) waypoints over a valid/ready handshake and drives each one as an X leg then a Y leg.
- Uses signed error arithmetic, an arrival tolerance, a slow approach band, and timed pivot turns between axes.
- Sits between the position source (carX/carY) and the wheel motor drivers (rWheel/lWheel).

Parameters:
- COORD_W, 32: coordinate width; all coordinates are signed two's complement.
- TOL, 0: arrival tolerance; an axis is aligned when |error| <= TOL.
- NEAR_BAND, 50: an |error| at or below this value, but above TOL, selects slow speed.
- DEPTH, 4: waypoint queue depth, >= 2.
- TURN_CYCLES, 8: number of clock cycles a 90-degree pivot turn lasts.
- TIMEOUT_CYCLES, 100000: leg watchdog limit. Used only with CAR_NAV_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- carX  in  COORD_W  current car X, signed.
- carY  in  COORD_W  current car Y, signed.
- wp_valid  in  1  waypoint offered.
- wp_x  in  COORD_W  waypoint X, signed.
- wp_y  in  COORD_W  waypoint Y, signed.
- wp_ready  out  1  queue not full.
- rWheel  out  2  right wheel: 00 stop, 01 forward, 10 reverse; 11 is never driven.
- lWheel  out  2  left wheel, same encoding as rWheel.
- slow  out  1  approach-speed qualifier for both wheels.
- busy  out  1  FSM not in IDLE.
- arrived  out  1  one-cycle pulse when a waypoint completes.
- wp_count  out  clog2(DEPTH+1)  queued waypoint count.

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE; queue is emptied; heading register = X.
  - Outputs: rWheel = lWheel = 00, slow = 0, busy = 0, arrived = 0, wp_count = 0, wp_ready = 1.
- Queue: FIFO with wp_ready = !full. A push occurs on wp_valid & wp_ready.
  - A push and a pop in the same cycle leave wp_count unchanged.
  - A push with wp_ready = 0 is ignored.
- Error arithmetic: dx = tarX - carX and dy = tarY - carY, sign-extended to COORD_W+1 bits so there is no overflow.
  - |d| is computed in COORD_W+1 bits.
  - Error is recomputed every cycle from the live carX/carY.
- States:
  - IDLE: wheels stop. If the queue is non-empty, pop the head into tarX/tarY and go to LOAD next cycle.
  - LOAD: if |dx| <= TOL and |dy| <= TOL, go to ARRIVE. Else if |dx| > TOL, the leg axis is X; otherwise it is Y. If heading differs from the leg axis, go to TURN; else go to DRIVE.
  - TURN: pivot with a cycle counter.
    - X to Y turn: rWheel = 01, lWheel = 10.
    - Y to X turn: rWheel = 10, lWheel = 01.
    - Lasts exactly TURN_CYCLES cycles. Then heading flips and the FSM goes to DRIVE.
  - DRIVE: uses the leg-axis error d.
    - d > 0: both wheels 01. d < 0: both wheels 10.
    - slow = 1 when |d| <= NEAR_BAND.
    - When |d| <= TOL: if the leg was X and |dy| > TOL, go to TURN (Y leg follows); otherwise go to ARRIVE.
    - Overshoot needs no special handling: the sign change reverses the wheels.
  - ARRIVE: wheels stop and arrived = 1 for one cycle. Go to IDLE; back-to-back waypoints are popped on the next cycle.
- Timing: wheel outputs are registered and reflect the state one cycle after each transition. Latency from push into an empty idle queue to the first non-stop wheel command is 3 cycles.
- Skipped legs: a waypoint already within TOL on X skips the X leg. A waypoint within TOL on Y skips the Y leg and its turn.
- Position jump mid-leg: the FSM re-evaluates every cycle; direction follows the sign of the error.
- The queue accepts pushes during every state, including TURN and DRIVE.
- A mid-operation reset aborts the leg immediately and stops the wheels asynchronously.

Optional Feature:
- CAR_NAV_TIMEOUT_EN defined:
  - A per-leg counter resets on entry to DRIVE.
  - Reaching TIMEOUT_CYCLES causes an abort: wheels stop, the queue is flushed, and the FSM enters FAULT.
  - The extra output fault = 1 while in FAULT.
  - FAULT is left only by reset.
- CAR_NAV_TIMEOUT_EN undefined: no counter, no FAULT state, no fault port; DRIVE may last indefinitely.

Test Plan:
- Reset then idle: hold reset = 0, then release with no pushes. Required: wheels 00/00, busy = 0, wp_ready = 1, wp_count = 0.
- Basic waypoint: car at (0,0), push (200,0), carX ramped +10/cycle.
  - Required: both wheels 01 with slow = 0 until carX = 150.
  - slow = 1 for carX in 150..199.
  - Stop at 200 with a single arrived pulse; no turn occurs.
- Two-leg negative waypoint: car at (100,100), push (-20,300).
  - Required: reverse 10/10 on the X leg.
  - Then a TURN of exactly 8 cycles with rWheel = 01, lWheel = 10.
  - Then forward on Y, then arrived.
- Queue full and overshoot: push 5 waypoints with DEPTH = 4.
  - Required: wp_ready = 0 after the 4th; the 5th is not accepted; wp_count = 4.
  - Forcing carX past tarX by 30 flips both wheels to 10 with slow = 1.
- Tolerance: TOL = 5, car at (0,0), push (3,-4). Required: LOAD goes straight to ARRIVE, arrived pulses, wheels never leave 00.
- Timeout (CAR_NAV_TIMEOUT_EN, TIMEOUT_CYCLES = 50): push (500,0) and hold carX = 0.
  - Required: fault = 1 at DRIVE cycle 50, wheels 00, wp_count = 0.
  - Pulsing reset = 0 clears fault.

Source files
------------

// File: rtl/car_waypoint_nav_if.sv
// Waypoint push channel for car_waypoint_nav: a valid/ready handshake carrying
// one signed (X,Y) coordinate pair per accepted transfer.
interface car_waypoint_nav_if #(
  parameter int COORD_W = 32
);
  logic                      wp_valid;
  logic signed [COORD_W-1:0] wp_x;
  logic signed [COORD_W-1:0] wp_y;
  logic                      wp_ready;

  modport master (
    output wp_valid,
    output wp_x,
    output wp_y,
    input  wp_ready
  );

  modport slave (
    input  wp_valid,
    input  wp_x,
    input  wp_y,
    output wp_ready
  );
endinterface

// File: rtl/car_waypoint_nav.sv
// car_waypoint_nav: queued waypoint navigator for a differential-drive car.
// Waypoints are popped from a small FIFO and driven as an X leg followed by a
// Y leg, with pivot turns between axes, an arrival tolerance and a slow band.
// Optional leg watchdog: define CAR_NAV_TIMEOUT_EN to add the FAULT state and
// the fault output.
module car_waypoint_nav #(
  parameter int COORD_W        = 32,
  parameter int TOL            = 0,
  parameter int NEAR_BAND      = 50,
  parameter int DEPTH          = 4,
  parameter int TURN_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic signed [COORD_W-1:0]        carX,
  input  logic signed [COORD_W-1:0]        carY,
  car_waypoint_nav_if.slave                wp,
  output logic [1:0]                       rWheel,
  output logic [1:0]                       lWheel,
  output logic                             slow,
  output logic                             busy,
  output logic                             arrived,
  output logic [$clog2(DEPTH+1)-1:0]       wp_count
`ifdef CAR_NAV_TIMEOUT_EN
  ,
  output logic                             fault
`endif
);

  // Errors carry one extra bit so tar - car never overflows.
  localparam int EW    = COORD_W + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TC_W  = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  localparam logic [EW-1:0] TOL_E  = EW'(TOL);
  localparam logic [EW-1:0] NEAR_E = EW'(NEAR_BAND);

  localparam logic [1:0] W_STOP = 2'b00;
  localparam logic [1:0] W_FWD  = 2'b01;
  localparam logic [1:0] W_REV  = 2'b10;

  // Reject configurations the datapath cannot represent.
  if (DEPTH < 2) begin : g_bad_depth
    $error("car_waypoint_nav: DEPTH must be at least 2");
  end
  if (TURN_CYCLES < 1) begin : g_bad_turn
    $error("car_waypoint_nav: TURN_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("car_waypoint_nav: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TURN,
    S_DRIVE,
`ifdef CAR_NAV_TIMEOUT_EN
    S_FAULT,
`endif
    S_ARRIVE
  } state_t;

  typedef enum logic {
    AX_X,
    AX_Y
  } axis_t;

  // Magnitude of a signed error; -2^COORD_W still fits as unsigned EW bits.
  function automatic logic [EW-1:0] abs_err(input logic signed [EW-1:0] v);
    logic [EW-1:0] u;
    u = v;
    return v[EW-1] ? (~u + EW'(1)) : u;
  endfunction

  // Wheel command that moves the car toward a positive or negative error.
  function automatic logic [1:0] dir_of(input logic signed [EW-1:0] v);
    if (v[EW-1]) begin
      return W_REV;
    end else if (v != '0) begin
      return W_FWD;
    end
    return W_STOP;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  state_t                    state_q, state_d;
  axis_t                     heading_q, heading_d;
  axis_t                     leg_q, leg_d;
  logic [TC_W-1:0]           turn_cnt_q, turn_cnt_d;
  logic [1:0]                rwheel_q, rwheel_d;
  logic [1:0]                lwheel_q, lwheel_d;
  logic                      slow_q, slow_d;
  logic                      arrived_q, arrived_d;
  logic signed [COORD_W-1:0] tar_x_q, tar_x_d;
  logic signed [COORD_W-1:0] tar_y_q, tar_y_d;

  logic [CNT_W-1:0]          count_q, count_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic signed [COORD_W-1:0] mem_x_q [DEPTH];
  logic signed [COORD_W-1:0] mem_x_d [DEPTH];
  logic signed [COORD_W-1:0] mem_y_q [DEPTH];
  logic signed [COORD_W-1:0] mem_y_d [DEPTH];

`ifdef CAR_NAV_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  logic push;
  logic pop;
  logic flush;
  logic empty;

  logic signed [EW-1:0] tx_e, ty_e, cx_e, cy_e;
  logic signed [EW-1:0] dx, dy, d_leg;
  logic [EW-1:0]        abs_dx, abs_dy, abs_d;
  axis_t                load_axis;

  assign empty       = (count_q == '0);
  assign wp.wp_ready = (count_q != CNT_W'(DEPTH));
  assign push        = wp.wp_valid & wp.wp_ready;

  assign rWheel   = rwheel_q;
  assign lWheel   = lwheel_q;
  assign slow     = slow_q;
  assign arrived  = arrived_q;
  assign busy     = (state_q != S_IDLE);
  assign wp_count = count_q;
`ifdef CAR_NAV_TIMEOUT_EN
  assign fault    = (state_q == S_FAULT);
`endif

  // Live signed errors from the current target and car position.
  always_comb begin
    tx_e      = {tar_x_q[COORD_W-1], tar_x_q};
    ty_e      = {tar_y_q[COORD_W-1], tar_y_q};
    cx_e      = {carX[COORD_W-1], carX};
    cy_e      = {carY[COORD_W-1], carY};
    dx        = tx_e - cx_e;
    dy        = ty_e - cy_e;
    abs_dx    = abs_err(dx);
    abs_dy    = abs_err(dy);
    d_leg     = (leg_q == AX_X) ? dx : dy;
    abs_d     = (leg_q == AX_X) ? abs_dx : abs_dy;
    load_axis = (abs_dx > TOL_E) ? AX_X : AX_Y;
  end

  // Next-state logic, queue pop request and next wheel commands.
  always_comb begin
    state_d    = state_q;
    heading_d  = heading_q;
    leg_d      = leg_q;
    turn_cnt_d = '0;
    rwheel_d   = W_STOP;
    lwheel_d   = W_STOP;
    slow_d     = 1'b0;
    arrived_d  = 1'b0;
    tar_x_d    = tar_x_q;
    tar_y_d    = tar_y_q;
    pop        = 1'b0;
    flush      = 1'b0;
`ifdef CAR_NAV_TIMEOUT_EN
    to_cnt_d   = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          tar_x_d = mem_x_q[rd_ptr_q];
          tar_y_d = mem_y_q[rd_ptr_q];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if ((abs_dx <= TOL_E) && (abs_dy <= TOL_E)) begin
          state_d = S_ARRIVE;
        end else begin
          leg_d   = load_axis;
          state_d = (heading_q != load_axis) ? S_TURN : S_DRIVE;
        end
      end
      S_TURN: begin
        // Pivot in place; direction depends on which way the car faces now.
        rwheel_d = (heading_q == AX_X) ? W_FWD : W_REV;
        lwheel_d = (heading_q == AX_X) ? W_REV : W_FWD;
        if (turn_cnt_q == TC_W'(TURN_CYCLES - 1)) begin
          heading_d = leg_q;
          state_d   = S_DRIVE;
        end else begin
          turn_cnt_d = turn_cnt_q + TC_W'(1);
        end
      end
      S_DRIVE: begin
        if (abs_d <= TOL_E) begin
          if ((leg_q == AX_X) && (abs_dy > TOL_E)) begin
            leg_d   = AX_Y;
            state_d = S_TURN;
          end else begin
            state_d = S_ARRIVE;
          end
        end else begin
          rwheel_d = dir_of(d_leg);
          lwheel_d = dir_of(d_leg);
          slow_d   = (abs_d <= NEAR_E);
`ifdef CAR_NAV_TIMEOUT_EN
          if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            rwheel_d = W_STOP;
            lwheel_d = W_STOP;
            slow_d   = 1'b0;
            flush    = 1'b1;
            state_d  = S_FAULT;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
`endif
        end
      end
      S_ARRIVE: begin
        arrived_d = 1'b1;
        state_d   = S_IDLE;
      end
`ifdef CAR_NAV_TIMEOUT_EN
      S_FAULT: begin
        state_d = S_FAULT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Queue pointers and occupancy; simultaneous push and pop cancel out.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_x_d  = mem_x_q;
    mem_y_d  = mem_y_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_x_d[wr_ptr_q] = wp.wp_x;
        mem_y_d[wr_ptr_q] = wp.wp_y;
        wr_ptr_d          = next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control state with asynchronous reset; outputs stop the moment reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      heading_q  <= AX_X;
      leg_q      <= AX_X;
      turn_cnt_q <= '0;
      rwheel_q   <= W_STOP;
      lwheel_q   <= W_STOP;
      slow_q     <= 1'b0;
      arrived_q  <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef CAR_NAV_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      heading_q  <= heading_d;
      leg_q      <= leg_d;
      turn_cnt_q <= turn_cnt_d;
      rwheel_q   <= rwheel_d;
      lwheel_q   <= lwheel_d;
      slow_q     <= slow_d;
      arrived_q  <= arrived_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
`ifdef CAR_NAV_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  // Coordinate storage; contents are qualified by the control state, so no reset.
  always_ff @(posedge clk) begin
    mem_x_q <= mem_x_d;
    mem_y_q <= mem_y_d;
    tar_x_q <= tar_x_d;
    tar_y_q <= tar_y_d;
  end

endmodule

// File: tb/tb_car_waypoint_nav.sv
// Directed bench for car_waypoint_nav: reset, single and two-leg waypoints,
// queue full / overshoot, tolerance skip and, when CAR_NAV_TIMEOUT_EN is
// defined, the leg watchdog.
module tb_car_waypoint_nav;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic signed [31:0] carX, carY, carTX, carTY;
  logic [1:0] rW, lW, rW_t, lW_t;
  logic slow, busy, arrived, slow_t, busy_t, arrived_t;
  logic [2:0] cnt, cnt_t;
`ifdef CAR_NAV_TIMEOUT_EN
  logic fault, fault_t;
`endif

  int checks = 0;
  int errors = 0;

  car_waypoint_nav_if #(.COORD_W(32)) wp_if ();
  car_waypoint_nav_if #(.COORD_W(32)) wpt_if ();

  car_waypoint_nav #(
    .COORD_W(32), .TOL(0), .NEAR_BAND(50), .DEPTH(4),
    .TURN_CYCLES(8), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset), .carX(carX), .carY(carY), .wp(wp_if.slave),
    .rWheel(rW), .lWheel(lW), .slow(slow), .busy(busy), .arrived(arrived),
    .wp_count(cnt)
`ifdef CAR_NAV_TIMEOUT_EN
    , .fault(fault)
`endif
  );

  car_waypoint_nav #(
    .COORD_W(32), .TOL(5), .NEAR_BAND(50), .DEPTH(4),
    .TURN_CYCLES(8), .TIMEOUT_CYCLES(50)
  ) dut_t (
    .clk(clk), .reset(reset), .carX(carTX), .carY(carTY), .wp(wpt_if.slave),
    .rWheel(rW_t), .lWheel(lW_t), .slow(slow_t), .busy(busy_t),
    .arrived(arrived_t), .wp_count(cnt_t)
`ifdef CAR_NAV_TIMEOUT_EN
    , .fault(fault_t)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic signed [31:0] x, input logic signed [31:0] y);
    wp_if.wp_valid = 1'b1;
    wp_if.wp_x     = x;
    wp_if.wp_y     = y;
    tick();
    wp_if.wp_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "bench time limit");
  end

  initial begin
    int   pulses;
    int   pulse_at;
    logic moved;

    reset = 1'b0;
    carX = 0; carY = 0; carTX = 0; carTY = 0;
    wp_if.wp_valid = 1'b0;  wp_if.wp_x = 0;  wp_if.wp_y = 0;
    wpt_if.wp_valid = 1'b0; wpt_if.wp_x = 0; wpt_if.wp_y = 0;
    repeat (3) tick();
    check("rst_rw", 32'(rW), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (2) tick();
    check("idle_rw", 32'(rW), 32'd0);
    check("idle_lw", 32'(lW), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(wp_if.wp_ready), 32'd1);
    check("idle_cnt", 32'(cnt), 32'd0);
    check("idle_slow", 32'(slow), 32'd0);
    check("idle_arr", 32'(arrived), 32'd0);

    // Basic single-leg waypoint with a +10/cycle ramp.
    push(200, 0);
    check("b_cnt1", 32'(cnt), 32'd1);
    tick();
    check("b_busy", 32'(busy), 32'd1);
    check("b_cnt0", 32'(cnt), 32'd0);
    tick();
    check("b_lat_rw", 32'(rW), 32'd0);
    for (int cx = 0; cx <= 200; cx += 10) begin
      carX = cx;
      tick();
      if (cx < 200) begin
        check("b_rw", 32'(rW), 32'd1);
        check("b_lw", 32'(lW), 32'd1);
        check("b_slow", 32'(slow), 32'(cx >= 150));
        check("b_arr", 32'(arrived), 32'd0);
      end else begin
        check("b_stop_rw", 32'(rW), 32'd0);
        check("b_stop_lw", 32'(lW), 32'd0);
      end
    end
    tick();
    check("b_arrived", 32'(arrived), 32'd1);
    check("b_idle", 32'(busy), 32'd0);
    tick();
    check("b_arr_once", 32'(arrived), 32'd0);

    // Two-leg waypoint: reverse X, X->Y pivot, forward Y.
    carX = 100; carY = 100;
    push(-20, 300);
    repeat (3) tick();
    check("t_x_rw", 32'(rW), 32'd2);
    check("t_x_lw", 32'(lW), 32'd2);
    check("t_x_slow", 32'(slow), 32'd0);
    carX = -20;
    tick();
    check("t_pre_turn", 32'(rW), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t_turn_rw", 32'(rW), 32'd1);
      check("t_turn_lw", 32'(lW), 32'd2);
    end
    tick();
    check("t_y_rw", 32'(rW), 32'd1);
    check("t_y_lw", 32'(lW), 32'd1);
    carY = 300;
    tick();
    check("t_stop", 32'(rW), 32'd0);
    tick();
    check("t_arrived", 32'(arrived), 32'd1);
    check("t_idle", 32'(busy), 32'd0);

    // Queue full, overshoot, FIFO order, asynchronous mid-leg reset.
    carX = 0; carY = 0;
    push(100, 0);
    tick();
    check("q_cnt0", 32'(cnt), 32'd0);
    push(-50, 0);
    push(10, 10);
    push(20, 20);
    check("q_cnt3", 32'(cnt), 32'd3);
    check("q_ready3", 32'(wp_if.wp_ready), 32'd1);
    push(30, 30);
    check("q_cnt4", 32'(cnt), 32'd4);
    check("q_full", 32'(wp_if.wp_ready), 32'd0);
    push(40, 40);
    check("q_reject", 32'(cnt), 32'd4);
    check("q_pivot_rw", 32'(rW), 32'd2);
    check("q_pivot_lw", 32'(lW), 32'd1);
    repeat (5) tick();
    check("q_fwd_rw", 32'(rW), 32'd1);
    check("q_fwd_slow", 32'(slow), 32'd0);
    carX = 130;
    tick();
    check("q_over_rw", 32'(rW), 32'd2);
    check("q_over_lw", 32'(lW), 32'd2);
    check("q_over_slow", 32'(slow), 32'd1);
    carX = 100;
    repeat (2) tick();
    check("q_arrived", 32'(arrived), 32'd1);
    check("q_cnt_keep", 32'(cnt), 32'd4);
    tick();
    check("q_pop_cnt", 32'(cnt), 32'd3);
    repeat (2) tick();
    check("q_order_rw", 32'(rW), 32'd2);
    check("q_order_slow", 32'(slow), 32'd0);
    reset = 1'b0;
    #1;
    check("q_arst_rw", 32'(rW), 32'd0);
    check("q_arst_lw", 32'(lW), 32'd0);
    check("q_arst_cnt", 32'(cnt), 32'd0);
    check("q_arst_busy", 32'(busy), 32'd0);
    check("q_arst_ready", 32'(wp_if.wp_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();

    // Tolerance (TOL = 5): already within tolerance on both axes.
    wpt_if.wp_valid = 1'b1; wpt_if.wp_x = 3; wpt_if.wp_y = -4;
    tick();
    wpt_if.wp_valid = 1'b0;
    pulses = 0; pulse_at = 0; moved = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (arrived_t) begin
        pulses++;
        pulse_at = i;
      end
      if ((rW_t != 2'b00) || (lW_t != 2'b00) || slow_t) moved = 1'b1;
    end
    check("tol_pulses", 32'(pulses), 32'd1);
    check("tol_when", 32'(pulse_at), 32'd3);
    check("tol_still", 32'(moved), 32'd0);
    check("tol_idle", 32'(busy_t), 32'd0);
    check("tol_cnt", 32'(cnt_t), 32'd0);
    check("tol_ready", 32'(wpt_if.wp_ready), 32'd1);

`ifdef CAR_NAV_TIMEOUT_EN
    // Leg watchdog: car never moves toward (500,0).
    carX = 0; carY = 0;
    push(500, 0);
    repeat (2) tick();
    push(40, 40);
    check("to_cnt1", 32'(cnt), 32'd1);
    repeat (48) tick();
    check("to_not_yet", 32'(fault), 32'd0);
    check("to_drive_rw", 32'(rW), 32'd1);
    tick();
    check("to_fault", 32'(fault), 32'd1);
    check("to_rw", 32'(rW), 32'd0);
    check("to_lw", 32'(lW), 32'd0);
    check("to_flush", 32'(cnt), 32'd0);
    tick();
    check("to_sticky", 32'(fault), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("to_cleared", 32'(fault), 32'd0);
    check("to_cleared_t", 32'(fault_t), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
